// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-port register file with registered reads and one write port.
// Define REGFILE_BYPASS_EN for write-first forwarding on same-edge read/write collisions.
module reg_file_mp #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int DEPTH   = 1 << ADDR_W,
  parameter int NUM_RD  = 2,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_val,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     wr_err
);

  // One extra bit so DEPTH == 2^ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0]        mem_q [DEPTH];
  logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
  logic [NUM_RD-1:0]        rd_val_q, rd_val_d;
  logic                     wr_err_q, wr_err_d;
  logic                     wr_in_range, wr_fire;
  logic [ADDR_W-1:0]        ra [NUM_RD];

  always_comb begin
    wr_in_range = {1'b0, wr_addr} < DEPTH_W;
    wr_fire     = wr_en && wr_in_range && !(ZERO_R0 && (wr_addr == '0));
    wr_err_d    = wr_en && !wr_in_range;
  end

  always_comb begin
    rd_data_d = '0;
    rd_val_d  = rd_en;
    for (int p = 0; p < NUM_RD; p++) begin
      ra[p] = rd_addr[p*ADDR_W +: ADDR_W];
      if (rd_en[p] && ({1'b0, ra[p]} < DEPTH_W) && !(ZERO_R0 && (ra[p] == '0))) begin
        rd_data_d[p*DATA_W +: DATA_W] = mem_q[ra[p]];
`ifdef REGFILE_BYPASS_EN
        if (wr_fire && (wr_addr == ra[p])) begin
          rd_data_d[p*DATA_W +: DATA_W] = wr_data;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_data_q <= '0;
      rd_val_q  <= '0;
      wr_err_q  <= 1'b0;
    end else begin
      if (wr_fire) begin
        mem_q[wr_addr] <= wr_data;
      end
      rd_data_q <= rd_data_d;
      rd_val_q  <= rd_val_d;
      wr_err_q  <= wr_err_d;
    end
  end

  assign rd_data = rd_data_q;
  assign rd_val  = rd_val_q;
  assign wr_err  = wr_err_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - self-checking bench for reg_file_mp (full-depth and DEPTH=24 instances).
// Honours REGFILE_BYPASS_EN when computing collision expectations.
module tb_reg_file_mp;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  rd_en = '0;
  logic [9:0]  rd_addr = '0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;

  logic [63:0] rd_data_a, rd_data_b;
  logic [1:0]  rd_val_a, rd_val_b;
  logic        wr_err_a, wr_err_b;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_on = 1'b0;

  always #5 clk = ~clk;

  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .NUM_RD(2), .ZERO_R0(1'b1)) dut_a (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .rd_val(rd_val_a), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err_a)
  );

  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .DEPTH(24), .NUM_RD(2), .ZERO_R0(1'b1)) dut_b (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_val(rd_val_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err_b)
  );

  // Reference model: architectural contents plus the result each read must deliver.
  int          dep [2] = '{32, 24};
  logic [31:0] mm [2][32];
  logic [31:0] exp_data [2][2];
  logic        exp_val [2][2];
  logic        exp_err [2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 32; i++) mm[d][i] = '0;
      for (int p = 0; p < 2; p++) begin
        exp_data[d][p] = '0;
        exp_val[d][p]  = 1'b0;
      end
      exp_err[d] = 1'b0;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < 32; i++) mm[d][i] = '0;
        for (int p = 0; p < 2; p++) begin
          exp_data[d][p] = '0;
          exp_val[d][p]  = 1'b0;
        end
        exp_err[d] = 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        int  wa;
        bit  wr_ok;
        wa    = int'(wr_addr);
        wr_ok = wr_en && (wa < dep[d]) && (wa != 0);
        for (int p = 0; p < 2; p++) begin
          int a;
          a = int'(rd_addr[p*5 +: 5]);
          exp_val[d][p] = rd_en[p];
          if (!rd_en[p] || a == 0 || a >= dep[d]) exp_data[d][p] = '0;
          else if (BYP && wr_ok && wa == a)       exp_data[d][p] = wr_data;
          else                                    exp_data[d][p] = mm[d][a];
        end
        exp_err[d] = wr_en && (wa >= dep[d]);
        if (wr_ok) mm[d][wa] = wr_data;
      end
    end
  end

  task automatic check(input string name, input int port, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s port%0d at %0t: got %h expected %h", name, port, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      for (int p = 0; p < 2; p++) begin
        check("model a_rd_data", p, rd_data_a[p*32 +: 32], exp_data[0][p]);
        check("model a_rd_val", p, 32'(rd_val_a[p]), 32'(exp_val[0][p]));
        check("model b_rd_data", p, rd_data_b[p*32 +: 32], exp_data[1][p]);
        check("model b_rd_val", p, 32'(rd_val_b[p]), 32'(exp_val[1][p]));
      end
      check("model a_wr_err", 0, 32'(wr_err_a), 32'(exp_err[0]));
      check("model b_wr_err", 0, 32'(wr_err_b), 32'(exp_err[1]));
    end
  end

  task automatic cyc(input logic [1:0] re, input logic [4:0] a0, input logic [4:0] a1,
                     input logic we, input logic [4:0] wa, input logic [31:0] wd);
    rd_en   = re;
    rd_addr = {a1, a0};
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    cmp_on = 1'b1;
    check("reset rd_val_a", 0, 32'(rd_val_a), 32'd0);
    check("reset rd_data_a", 0, rd_data_a[31:0], 32'd0);
    check("reset wr_err_b", 0, 32'(wr_err_b), 32'd0);
    #1 rst = 1'b0;

    for (int a = 0; a < 32; a++) begin
      cyc(2'b11, 5'(a), 5'(a), 1'b0, 5'd0, 32'd0);
      check("init rd_data_a", 0, rd_data_a[31:0], 32'd0);
      check("init rd_data_a", 1, rd_data_a[63:32], 32'd0);
      check("init rd_val_a", 0, 32'(rd_val_a), 32'd3);
    end

    cyc(2'b00, 5'd0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF);
    cyc(2'b11, 5'd5, 5'd5, 1'b0, 5'd0, 32'd0);
    check("wr5 a", 0, rd_data_a[31:0], 32'hDEADBEEF);
    check("wr5 a", 1, rd_data_a[63:32], 32'hDEADBEEF);
    check("wr5 b", 0, rd_data_b[31:0], 32'hDEADBEEF);

    cyc(2'b00, 5'd0, 5'd0, 1'b1, 5'd7, 32'hAAAA0007);
    cyc(2'b01, 5'd7, 5'd7, 1'b1, 5'd7, 32'h12345678);
    check("collide a", 0, rd_data_a[31:0], BYP ? 32'h12345678 : 32'hAAAA0007);
    check("collide idle port data", 1, rd_data_a[63:32], 32'd0);
    check("collide idle port val", 0, 32'(rd_val_a), 32'd1);
    cyc(2'b11, 5'd7, 5'd7, 1'b0, 5'd0, 32'd0);
    check("after collide a", 1, rd_data_a[63:32], 32'h12345678);

    cyc(2'b10, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF);
    check("r0 collide a", 1, rd_data_a[63:32], 32'd0);
    check("r0 wr_err_a", 0, 32'(wr_err_a), 32'd0);
    cyc(2'b11, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
    check("r0 read a", 0, rd_data_a[31:0], 32'd0);
    check("r0 read val", 0, 32'(rd_val_a), 32'd3);

    cyc(2'b00, 5'd0, 5'd0, 1'b1, 5'd30, 32'h00000055);
    check("oor wr_err_b", 0, 32'(wr_err_b), 32'd1);
    check("oor wr_err_a", 0, 32'(wr_err_a), 32'd0);
    cyc(2'b11, 5'd30, 5'd23, 1'b0, 5'd0, 32'd0);
    check("oor wr_err_b drop", 0, 32'(wr_err_b), 32'd0);
    check("oor read b", 0, rd_data_b[31:0], 32'd0);
    check("oor read b val", 0, 32'(rd_val_b), 32'd3);
    check("oor read a", 0, rd_data_a[31:0], 32'h00000055);
    cyc(2'b00, 5'd0, 5'd0, 1'b1, 5'd23, 32'h00002323);
    cyc(2'b11, 5'd23, 5'd24, 1'b0, 5'd0, 32'd0);
    check("top entry b", 0, rd_data_b[31:0], 32'h00002323);
    check("past top b", 1, rd_data_b[63:32], 32'd0);

    for (int i = 0; i < 40; i++) begin
      cyc(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
          1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
    end

    for (int a = 1; a < 32; a++) begin
      cyc(2'b11, 5'(a), 5'(32 - a), 1'b0, 5'd0, 32'd0);
      if (a == 16) begin
        #2 rst = 1'b1;
        #1;
        check("async rst rd_val_a", 0, 32'(rd_val_a), 32'd0);
        check("async rst rd_val_b", 0, 32'(rd_val_b), 32'd0);
      end
      if (a == 18) #1 rst = 1'b0;
    end
    cyc(2'b11, 5'd5, 5'd7, 1'b0, 5'd0, 32'd0);
    check("post rst a", 0, rd_data_a[31:0], 32'd0);
    check("post rst a", 1, rd_data_a[63:32], 32'd0);
    check("post rst val", 0, 32'(rd_val_a), 32'd3);
    cyc(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
